// File: rtl/pipo_share_arbiter.sv
// Round-robin arbiter sharing one parallel-in/parallel-out holding register
// among NREQ requesters, presented downstream with a valid/ready handshake.
module pipo_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OWNER_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] datain,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      dataout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OWNER_W-1:0]    owner
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [OWNER_W-1:0] win_idx, idx;
  logic [WIDTH-1:0]   win_data;
  logic               found, can_load, load;

  // Rotating-priority search: first set request at or above rr_ptr, wrapping.
  // NREQ is a power of two, so the OWNER_W-bit add wraps naturally.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + OWNER_W'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Grant only when the register can take a word; suppressed during reset.
  always_comb begin
    can_load = (state_q == StEmpty) || out_ready;
    load     = reset && can_load && found;
    gnt      = '0;
    win_data = '0;
    if (load) gnt[win_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_data = datain[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: load on grant (drain and load may coincide), drain otherwise.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    if (load) begin
      state_d  = StFull;
      data_d   = win_data;
      owner_d  = win_idx;
      rr_ptr_d = win_idx + OWNER_W'(1);
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StEmpty;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
    end
  end

  assign dataout   = data_q;
  assign owner     = owner_q;
  assign out_valid = (state_q == StFull);

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Directed self-checking bench for pipo_share_arbiter.
module tb_pipo_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] datain;
  logic [3:0]  gnt;
  logic [3:0]  dataout;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  owner;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipo_share_arbiter #(.NREQ(4), .WIDTH(4), .OWNER_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .datain    (datain),
    .gnt       (gnt),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .owner     (owner)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; out_ready = 1'b1; datain = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      n_cmp++;
      if (gnt !== 4'b0 || out_valid !== 1'b0 || dataout !== 4'h0 || owner !== 2'd0) begin
        n_fail++;
        $display("FAIL reset c%0d: gnt=%b v=%b d=%h o=%0d required 0000 0 0 0",
                 c, gnt, out_valid, dataout, owner);
      end
    end
  endtask

  task automatic test_single();
    reset = 1'b1; req = 4'b0010; datain = 16'h00A0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL single_gnt: got %b required 0010", gnt);
    end
    tick();
    req = 4'b0000;
    n_cmp++;
    if (out_valid !== 1'b1 || dataout !== 4'hA || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL single_out: v=%b d=%h o=%0d required 1 a 1", out_valid, dataout, owner);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || dataout !== 4'hA) begin
      n_fail++; $display("FAIL single_drain: v=%b d=%h required 0 a", out_valid, dataout);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [5];
    logic [1:0] exp_g [5];
    exp_d = '{4'h3, 4'h7, 4'hB, 4'hE, 4'h3};
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 4'b1111; datain = 16'hEB73; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (gnt !== (4'b0001 << exp_g[c])) begin
        n_fail++;
        $display("FAIL rr_gnt c%0d: got %b required %b", c, gnt, 4'b0001 << exp_g[c]);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || dataout !== exp_d[c] || owner !== exp_g[c]) begin
        n_fail++;
        $display("FAIL rr_out c%0d: v=%b d=%h o=%0d required 1 %h %0d",
                 c, out_valid, dataout, owner, exp_d[c], exp_g[c]);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here; only requester 3 asks.
    req = 4'b1000; datain = 16'h5000; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL bp_first_gnt: got %b required 1000", gnt);
    end
    tick();
    out_ready = 1'b0; datain = 16'h6000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_fail++; $display("FAIL bp_gnt c%0d: got %b required 0000", c, gnt);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || dataout !== 4'h5 || owner !== 2'd3) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: v=%b d=%h o=%0d required 1 5 3",
                 c, out_valid, dataout, owner);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release_gnt: got %b required 1000", gnt);
    end
    tick();
    req = 4'b0000;
    n_cmp++;
    if (out_valid !== 1'b1 || dataout !== 4'h6) begin
      n_fail++; $display("FAIL bp_release_out: v=%b d=%h required 1 6", out_valid, dataout);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    // rr_ptr is 0 here; requester 2 alone loads 9.
    req = 4'b0100; datain = 16'h0900; out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || dataout !== 4'h9 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL mrst_load: v=%b d=%h o=%0d required 1 9 2", out_valid, dataout, owner);
    end
    reset = 1'b0; req = 4'b1111; datain = 16'h4321;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL mrst_gnt: got %b required 0000", gnt);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || dataout !== 4'h0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL mrst_clear: v=%b d=%h o=%0d required 0 0 0", out_valid, dataout, owner);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL mrst_after_gnt: got %b required 0001", gnt);
    end
    tick();
    n_cmp++;
    if (dataout !== 4'h1 || owner !== 2'd0) begin
      n_fail++; $display("FAIL mrst_after_out: d=%h o=%0d required 1 0", dataout, owner);
    end
  endtask

  task automatic test_random();
    logic       m_full;
    logic [1:0] m_ptr, m_owner, m_win;
    logic [3:0] m_data, exp_gnt;
    logic       hit;
    int         idx;
    reset = 1'b0; req = 4'b0000;
    tick();
    reset = 1'b1;
    m_full = 1'b0; m_ptr = 2'd0; m_owner = 2'd0; m_data = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) datain[s*4 +: 4] = 4'($urandom % 16);
      req       = 4'($urandom % 16);
      out_ready = 1'($urandom % 2);
      hit = 1'b0; m_win = 2'd0; exp_gnt = 4'b0000;
      if (!m_full || out_ready) begin
        for (int k = 0; k < 4; k++) begin
          idx = (int'(m_ptr) + k) % 4;
          if (!hit && req[idx]) begin
            hit = 1'b1; m_win = 2'(idx);
          end
        end
      end
      if (hit) exp_gnt[m_win] = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== exp_gnt) begin
        n_fail++; $display("FAIL rand_gnt c%0d: got %b required %b", c, gnt, exp_gnt);
      end
      if (hit) begin
        m_full = 1'b1; m_data = datain[m_win*4 +: 4]; m_owner = m_win; m_ptr = m_win + 2'd1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
      tick();
      n_cmp++;
      if (out_valid !== m_full || dataout !== m_data || owner !== m_owner) begin
        n_fail++;
        $display("FAIL rand_out c%0d: v=%b d=%h o=%0d required %b %h %0d",
                 c, out_valid, dataout, owner, m_full, m_data, m_owner);
      end
    end
  endtask

  initial begin
    reset = 1'b0; req = 4'b0000; datain = 16'h0000; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
